// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: operating mode and phase/extension helpers.
package cordic_pkg;

   typedef enum logic {
      CORDIC_ROTATE = 1'b0,
      CORDIC_VECTOR = 1'b1
   } cordic_mode_e;

   function automatic logic [31:0] quarter(int unsigned pw);
      return 32'd1 << (pw - 2);
   endfunction

   function automatic logic [31:0] half(int unsigned pw);
      return 32'd1 << (pw - 1);
   endfunction

   function automatic logic [31:0] three_q(int unsigned pw);
      return 32'd3 << (pw - 2);
   endfunction

   // {sign, v, zeros} in ww bits: sign-extend v from iw bits, then scale up to leave one guard MSB.
   function automatic logic [31:0] sign_ext(logic [31:0] v, int unsigned iw, int unsigned ww);
      logic [31:0] t;
      t = v << (32 - iw);
      t = 32'($signed(t) >>> (32 - iw));
      return t << (ww - iw - 1);
   endfunction

endpackage

// File: rtl/cordic_skid_buf.sv
// Generic 2-entry valid/ready register slice: output register plus one skid register.
module cordic_skid_buf #(
   parameter int unsigned DW = 8
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data
);

   logic          out_valid_q, skid_valid_q;
   logic [DW-1:0] out_data_q, skid_data_q;

   assign o_ready = !skid_valid_q;
   assign o_valid = out_valid_q;
   assign o_data  = out_data_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else if (!out_valid_q || i_ready) begin
         // Output slot frees up: a parked beat has priority (input is blocked while it is parked).
         if (skid_valid_q) begin
            out_data_q   <= skid_data_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q <= i_valid;
            if (i_valid) begin
               out_data_q <= i_data;
            end
         end
      end else if (i_valid && !skid_valid_q) begin
         skid_data_q  <= i_data;
         skid_valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/cordic_prerot_stream.sv
// CORDIC front end: sign-extends (x,y), folds the operand into the convergence range and
// corrects the phase, then registers the beat through a 2-entry skid slice.
module cordic_prerot_stream
   import cordic_pkg::*;
#(
   parameter int unsigned IW = 12,
   parameter int unsigned WW = 15,
   parameter int unsigned PW = 19,
   parameter int unsigned TW = 4
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic          i_mode,
   input  logic [IW-1:0] i_xval,
   input  logic [IW-1:0] i_yval,
   input  logic [PW-1:0] i_phase,
   input  logic [TW-1:0] i_tag,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [WW-1:0] o_xval,
   output logic [WW-1:0] o_yval,
   output logic [PW-1:0] o_phase,
   output logic          o_mode,
   output logic [TW-1:0] o_tag
);

   if (WW < IW + 2) begin : g_bad_ww
      $error("cordic_prerot_stream: WW must be at least IW+2");
   end
   if (PW < 4) begin : g_bad_pw
      $error("cordic_prerot_stream: PW must be at least 4");
   end

   localparam int unsigned DW = 1 + TW + PW + 2 * WW;
   localparam logic [PW-1:0] Q = PW'(quarter(PW));
   localparam logic [PW-1:0] H = PW'(half(PW));
   localparam logic [PW-1:0] T = PW'(three_q(PW));

   logic signed [WW-1:0] ex, ey, fx, fy;
   logic [PW-1:0]        fph;
   logic [DW-1:0]        out_data;

   assign ex = WW'(sign_ext(32'(i_xval), IW, WW));
   assign ey = WW'(sign_ext(32'(i_yval), IW, WW));

   always_comb begin
      fx  = ex;
      fy  = ey;
      fph = i_phase;
      if (cordic_mode_e'(i_mode) == CORDIC_ROTATE) begin
         case (i_phase[PW-1 -: 3])
            3'b001, 3'b010: begin fx = -ey; fy = ex;  fph = i_phase - Q; end
            3'b011, 3'b100: begin fx = -ex; fy = -ey; fph = i_phase - H; end
            3'b101, 3'b110: begin fx = ey;  fy = -ex; fph = i_phase - T; end
            default: ;
         endcase
      end else if (ex[WW-1]) begin
         if (!ey[WW-1]) begin
            fx  = ey;
            fy  = -ex;
            fph = i_phase + Q;
         end else begin
            fx  = -ey;
            fy  = ex;
            fph = i_phase - Q;
         end
      end
   end

   cordic_skid_buf #(
      .DW(DW)
   ) u_skid (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_data   ({i_mode, i_tag, fph, fy, fx}),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_data   (out_data)
   );

   assign {o_mode, o_tag, o_phase, o_yval, o_xval} = out_data;

endmodule

// File: tb/tb_cordic_prerot_stream.sv
// Self-checking bench for cordic_prerot_stream: directed cases, backpressure, reset and random stream.
module tb_cordic_prerot_stream;

   localparam int unsigned IW = 12;
   localparam int unsigned WW = 15;
   localparam int unsigned PW = 19;
   localparam int unsigned TW = 4;

   typedef struct packed {
      logic          mode;
      logic [TW-1:0] tag;
      logic [PW-1:0] ph;
      logic [WW-1:0] y;
      logic [WW-1:0] x;
   } beat_t;

   logic          clk, rst_n;
   logic          i_valid, o_ready, i_mode, o_valid, i_ready, o_mode;
   logic [IW-1:0] i_xval, i_yval;
   logic [PW-1:0] i_phase, o_phase;
   logic [TW-1:0] i_tag, o_tag;
   logic [WW-1:0] o_xval, o_yval;

   int checks = 0;
   int errors = 0;
   beat_t exp_q[$];

   cordic_prerot_stream #(
      .IW(IW), .WW(WW), .PW(PW), .TW(TW)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_mode   (i_mode),
      .i_xval   (i_xval),
      .i_yval   (i_yval),
      .i_phase  (i_phase),
      .i_tag    (i_tag),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_xval   (o_xval),
      .o_yval   (o_yval),
      .o_phase  (o_phase),
      .o_mode   (o_mode),
      .o_tag    (o_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Reference: value scaling by 2^(WW-IW-1), quadrant folding by rotation, phase mod 2^PW.
   function automatic beat_t model(logic md, logic [IW-1:0] xv, logic [IW-1:0] yv,
                                   logic [PW-1:0] ph, logic [TW-1:0] tg);
      beat_t b;
      int sc, q, ex, ey, rx, ry, off;
      sc  = 1 << (WW - IW - 1);
      q   = 1 << (PW - 2);
      ex  = int'($signed(xv)) * sc;
      ey  = int'($signed(yv)) * sc;
      rx  = ex;
      ry  = ey;
      off = 0;
      if (!md) begin
         case (int'(ph) / (1 << (PW - 3)))
            1, 2:    begin rx = -ey; ry = ex;  off = -q;     end
            3, 4:    begin rx = -ex; ry = -ey; off = -2 * q; end
            5, 6:    begin rx = ey;  ry = -ex; off = -3 * q; end
            default: ;
         endcase
      end else if (ex < 0) begin
         if (ey >= 0) begin rx = ey;  ry = -ex; off = q;  end
         else         begin rx = -ey; ry = ex;  off = -q; end
      end
      b.mode = md;
      b.tag  = tg;
      b.x    = rx[WW-1:0];
      b.y    = ry[WW-1:0];
      b.ph   = PW'(int'(ph) + off);
      return b;
   endfunction

   // Compare process: scoreboard pop on output handshake, stall stability, push on input handshake.
   logic  prev_stall = 1'b0;
   beat_t prev_out;
   always @(negedge clk) begin
      beat_t cur, e;
      cur = '{mode: o_mode, tag: o_tag, ph: o_phase, y: o_yval, x: o_xval};
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_hold", 64'(o_valid), 64'd1);
            chk("stall_data_hold", 64'(cur), 64'(prev_out));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_beat", 64'(o_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beat", 64'(cur), 64'(e));
            end
         end
         if (i_valid && o_ready) exp_q.push_back(model(i_mode, i_xval, i_yval, i_phase, i_tag));
         prev_stall = o_valid && !i_ready;
         prev_out   = cur;
      end
   end

   task automatic step(output logic acc);
      @(negedge clk);
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic md, input logic [IW-1:0] xv, input logic [IW-1:0] yv,
                           input logic [PW-1:0] ph, input logic [TW-1:0] tg);
      i_valid = 1'b1;
      i_mode  = md;
      i_xval  = xv;
      i_yval  = yv;
      i_phase = ph;
      i_tag   = tg;
   endtask

   task automatic rand_beat();
      set_beat(1'($urandom()), IW'($urandom()), IW'($urandom()), PW'($urandom()),
               TW'($urandom()));
   endtask

   task automatic drain();
      logic acc;
      int   n;
      i_valid = 1'b0;
      i_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step(acc);
         n++;
      end
      step(acc);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
      chk({tag, "_o_ready"}, 64'(o_ready), 64'd1);
      chk({tag, "_data"}, 64'({o_mode, o_tag, o_phase, o_yval, o_xval}), 64'd0);
   endtask

   initial begin
      beat_t m;
      logic  acc;
      int    acc_cnt, sent, cyc;

      rst_n   = 1'b0;
      i_ready = 1'b0;
      set_beat(1'b0, '0, '0, '0, '0);
      i_valid = 1'b0;
      #1;
      check_reset_outputs("reset");

      // Hand-computed expectations that pin the model.
      m = model(1'b0, 12'h400, 12'h000, 19'h10000, 4'h3);
      chk("model_rot_p001", 64'({m.x, m.y, m.ph}), 64'({15'h0000, 15'h1000, 19'h70000}));
      m = model(1'b0, 12'h7FF, 12'h800, 19'h31234, 4'h0);
      chk("model_rot_p011", 64'({m.x, m.y, m.ph}), 64'({15'h6004, 15'h2000, 19'h71234}));
      m = model(1'b1, 12'hF00, 12'hFB0, 19'h10000, 4'h0);
      chk("model_vec_qiii", 64'({m.x, m.y, m.ph}), 64'({15'h0140, 15'h7C00, 19'h70000}));
      m = model(1'b1, 12'hFFC, 12'h008, 19'h7FFFF, 4'h0);
      chk("model_vec_qii", 64'({m.x, m.y, m.ph}), 64'({15'h0020, 15'h0010, 19'h1FFFF}));

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ROTATE beat with 1-cycle latency.
      i_ready = 1'b1;
      set_beat(1'b0, 12'h400, 12'h000, 19'h10000, 4'h3);
      step(acc);
      i_valid = 1'b0;
      chk("lat_accept", 64'(acc), 64'd1);
      chk("lat_o_valid", 64'(o_valid), 64'd1);
      chk("lat_data", 64'({o_xval, o_yval, o_phase, o_tag}),
          64'({15'h0000, 15'h1000, 19'h70000, 4'h3}));
      drain();

      // ROTATE octant sweep at extreme operands, then VECTOR cases including phase wrap.
      for (int p = 0; p < 8; p++) begin
         set_beat(1'b0, 12'h7FF, 12'h800, PW'((p << (PW - 3)) | 19'h01234), 4'(p));
         step(acc);
      end
      set_beat(1'b1, 12'hF00, 12'hFB0, 19'h10000, 4'h9);
      step(acc);
      set_beat(1'b1, 12'hFFC, 12'h008, 19'h7FFFF, 4'hA);
      step(acc);
      set_beat(1'b1, 12'h123, 12'h800, 19'h00005, 4'hB);
      step(acc);
      drain();

      // Backpressure: output stalled, 10-beat burst.
      i_ready = 1'b0;
      acc_cnt = 0;
      rand_beat();
      for (int c = 0; c < 5; c++) begin
         step(acc);
         if (acc) begin acc_cnt++; rand_beat(); end
      end
      chk("bp_accepts", 64'(acc_cnt), 64'd2);
      chk("bp_o_ready_low", 64'(o_ready), 64'd0);
      i_ready = 1'b1;
      cyc = 0;
      while (acc_cnt < 10 && cyc < 40) begin
         step(acc);
         cyc++;
         if (acc) begin acc_cnt++; rand_beat(); end
      end
      chk("bp_all_accepted", 64'(acc_cnt), 64'd10);
      drain();

      // Reset with the skid full.
      i_ready = 1'b0;
      rand_beat();
      for (int c = 0; c < 4; c++) begin
         step(acc);
         if (acc) rand_beat();
      end
      chk("pre_reset_skid_full", 64'(o_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      i_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      i_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("post_reset_no_beat", 64'(o_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      set_beat(1'b1, 12'h800, 12'h7FF, 19'h40000, 4'h5);
      step(acc);
      drain();

      // Random valid/ready stream.
      i_valid = 1'b0;
      sent = 0;
      cyc  = 0;
      acc  = 1'b0;
      while (sent < 10000 && cyc < 60000) begin
         i_ready = ($urandom_range(0, 3) != 0);
         if (!i_valid || acc) begin
            if ($urandom_range(0, 3) != 0) rand_beat();
            else i_valid = 1'b0;
         end
         step(acc);
         cyc++;
         if (acc) sent++;
      end
      chk("random_sent", 64'(sent), 64'd10000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
